// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl: coin-operated vending credit controller.
// Collects coins into a credit register, dispenses an item once the price is
// reached, then pays change (or a full refund on cancel) one coin at a time
// over a valid/ready handshake to the coin dispenser.
module vend_credit_ctrl #(
  parameter int W     = 4,
  parameter int PRICE = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coin_valid,
  input  logic [1:0]       coin_type,
  input  logic             cancel,
  output logic             coin_reject,
  output logic             item_out,
  output logic             chg_valid,
  output logic [1:0]       chg_type,
  input  logic             chg_ready,
  output logic [W-1:0]     credit,
  output logic             busy,
  output logic [CNT_W-1:0] sales_count
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_VEND    = 2'd1,
    S_CHANGE  = 2'd2,
    S_REFUND  = 2'd3
  } state_t;

  // Sums are formed one bit wider than the credit register so an overflow
  // can be seen before it would wrap.
  localparam logic [W:0] MAX_CREDIT = {1'b0, {W{1'b1}}};
  localparam logic [W:0] PRICE_X    = (W+1)'(PRICE);
  localparam logic [W-1:0] PRICE_W  = W'(PRICE);

  state_t          state_q;
  logic [W-1:0]    credit_q;
  logic [CNT_W-1:0] sales_q;
  logic            reject_q;

  logic [W:0]      coin_val_s;
  logic            coin_ok_s;
  logic [W:0]      sum_s;
  logic            fits_s;
  logic [W-1:0]    chg_val_s;
  logic [1:0]      chg_type_s;
  logic [W-1:0]    remainder_s;
  logic [W-1:0]    pay_left_s;

  // Value of the presented coin; the invalid code carries no value.
  always_comb begin
    coin_val_s = (W+1)'(0);
    case (coin_type)
      2'b00:   coin_val_s = (W+1)'(1);
      2'b01:   coin_val_s = (W+1)'(2);
      2'b10:   coin_val_s = (W+1)'(4);
      default: coin_val_s = (W+1)'(0);
    endcase
  end

  assign coin_ok_s = coin_valid && (coin_type != 2'b11);
  assign sum_s     = {1'b0, credit_q} + coin_val_s;
  assign fits_s    = (sum_s <= MAX_CREDIT);

  // Greedy change selection from the registered credit: largest coin that fits.
  always_comb begin
    chg_val_s  = W'(1);
    chg_type_s = 2'b00;
    if (credit_q >= W'(4)) begin
      chg_val_s  = W'(4);
      chg_type_s = 2'b10;
    end else if (credit_q >= W'(2)) begin
      chg_val_s  = W'(2);
      chg_type_s = 2'b01;
    end else begin
      chg_val_s  = W'(1);
      chg_type_s = 2'b00;
    end
  end

  // VEND is only entered with credit >= PRICE, so this never underflows there.
  assign remainder_s = credit_q - PRICE_W;
  assign pay_left_s  = credit_q - chg_val_s;

  // Controller state, credit, sales counter and the coin-reject pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_COLLECT;
      credit_q <= '0;
      sales_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      case (state_q)
        S_COLLECT: begin
          if (cancel) begin
            // Cancel beats a coin arriving in the same cycle.
            reject_q <= coin_valid;
            if (credit_q != '0) begin
              state_q <= S_REFUND;
            end else begin
              state_q <= S_COLLECT;
            end
          end else if (coin_valid) begin
            if (coin_ok_s && fits_s) begin
              credit_q <= sum_s[W-1:0];
              if (sum_s >= PRICE_X) begin
                state_q <= S_VEND;
              end else begin
                state_q <= S_COLLECT;
              end
            end else begin
              reject_q <= 1'b1;
            end
          end else begin
            state_q <= S_COLLECT;
          end
        end
        S_VEND: begin
          reject_q <= coin_valid;
          credit_q <= remainder_s;
          sales_q  <= sales_q + CNT_W'(1);
          if (remainder_s != '0) begin
            state_q <= S_CHANGE;
          end else begin
            state_q <= S_COLLECT;
          end
        end
        S_CHANGE, S_REFUND: begin
          reject_q <= coin_valid;
          if (chg_ready) begin
            credit_q <= pay_left_s;
            if (pay_left_s == '0) begin
              state_q <= S_COLLECT;
            end else begin
              state_q <= state_q;
            end
          end else begin
            state_q <= state_q;
          end
        end
        default: begin
          state_q  <= S_COLLECT;
          credit_q <= '0;
        end
      endcase
    end
  end

  assign coin_reject = reject_q;
  assign item_out    = (state_q == S_VEND);
  assign chg_valid   = (state_q == S_CHANGE) || (state_q == S_REFUND);
  assign chg_type    = chg_type_s;
  assign busy        = (state_q != S_COLLECT);
  assign credit      = credit_q;
  assign sales_count = sales_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Bench for vend_credit_ctrl: two instances (PRICE 5 and PRICE 15) share one
// input stream; a behavioural model per instance queues the expected
// observations and a negedge monitor compares them against the outputs.
module tb_vend_credit_ctrl;

  localparam int W     = 4;
  localparam int CNT_W = 8;
  localparam int MAXC  = 15;

  localparam int K_STATUS = 0;
  localparam int K_REJ    = 1;
  localparam int K_ITEM   = 2;
  localparam int K_CHG    = 3;

  localparam int PH_IDLE = 0;
  localparam int PH_VEND = 1;
  localparam int PH_PAY  = 2;

  typedef struct packed {
    int kind;
    int a;
    int b;
    int c;
    int d;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       cancel = 1'b0;
  logic       chg_ready = 1'b1;

  logic             o_rej   [2];
  logic             o_item  [2];
  logic             o_cv    [2];
  logic [1:0]       o_ct    [2];
  logic [W-1:0]     o_cr    [2];
  logic             o_busy  [2];
  logic [CNT_W-1:0] o_sc    [2];

  int checks = 0;
  int errors = 0;

  int m_credit [2];
  int m_phase  [2];
  int m_sales  [2];
  bit m_rej    [2];
  int m_price  [2];

  ev_t evq [2][$];
  ev_t mon_e;

  vend_credit_ctrl #(.W(W), .PRICE(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .coin_reject(o_rej[0]), .item_out(o_item[0]),
    .chg_valid(o_cv[0]), .chg_type(o_ct[0]), .chg_ready(chg_ready),
    .credit(o_cr[0]), .busy(o_busy[0]), .sales_count(o_sc[0])
  );

  vend_credit_ctrl #(.W(W), .PRICE(15), .CNT_W(CNT_W)) dut15 (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .coin_reject(o_rej[1]), .item_out(o_item[1]),
    .chg_valid(o_cv[1]), .chg_type(o_ct[1]), .chg_ready(chg_ready),
    .credit(o_cr[1]), .busy(o_busy[1]), .sales_count(o_sc[1])
  );

  function automatic int coin_value(input int t);
    if (t == 0) return 1;
    if (t == 1) return 2;
    if (t == 2) return 4;
    return 0;
  endfunction

  function automatic int greedy_value(input int c);
    if (c >= 4) return 4;
    if (c >= 2) return 2;
    return 1;
  endfunction

  function automatic int greedy_code(input int c);
    if (c >= 4) return 2;
    if (c >= 2) return 1;
    return 0;
  endfunction

  task automatic chk(input string name, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got %0d expected %0d", name, i, $time, act, exp);
    end
  endtask

  // Queue what instance i should show during the cycle now starting.
  task automatic emit(input int i);
    ev_t e;
    e = '{kind: K_STATUS, a: m_credit[i], b: (m_phase[i] != PH_IDLE) ? 1 : 0,
          c: m_sales[i], d: (m_phase[i] == PH_PAY) ? 1 : 0};
    evq[i].push_back(e);
    if (m_rej[i]) begin
      e = '{kind: K_REJ, a: 0, b: 0, c: 0, d: 0};
      evq[i].push_back(e);
    end
    if (m_phase[i] == PH_VEND) begin
      e = '{kind: K_ITEM, a: m_credit[i], b: m_sales[i], c: 0, d: 0};
      evq[i].push_back(e);
    end
    if (m_phase[i] == PH_PAY && chg_ready) begin
      e = '{kind: K_CHG, a: greedy_code(m_credit[i]), b: m_credit[i], c: 0, d: 0};
      evq[i].push_back(e);
    end
  endtask

  // Advance instance i's model across the coming clock edge.
  task automatic step(input int i);
    bit nrej;
    int v;
    nrej = 1'b0;
    if (reset) begin
      m_phase[i]  = PH_IDLE;
      m_credit[i] = 0;
      m_sales[i]  = 0;
      m_rej[i]    = 1'b0;
    end else begin
      if (m_phase[i] == PH_IDLE) begin
        if (cancel) begin
          nrej = coin_valid;
          if (m_credit[i] > 0) m_phase[i] = PH_PAY;
        end else if (coin_valid) begin
          v = coin_value(int'(coin_type));
          if (v == 0 || m_credit[i] + v > MAXC) begin
            nrej = 1'b1;
          end else begin
            m_credit[i] += v;
            if (m_credit[i] >= m_price[i]) m_phase[i] = PH_VEND;
          end
        end
      end else if (m_phase[i] == PH_VEND) begin
        nrej = coin_valid;
        m_credit[i] -= m_price[i];
        m_sales[i] = (m_sales[i] + 1) % 256;
        m_phase[i] = (m_credit[i] > 0) ? PH_PAY : PH_IDLE;
      end else begin
        nrej = coin_valid;
        if (chg_ready) begin
          m_credit[i] -= greedy_value(m_credit[i]);
          if (m_credit[i] == 0) m_phase[i] = PH_IDLE;
        end
      end
      m_rej[i] = nrej;
    end
  endtask

  task automatic cyc(input bit r, input bit cv, input int ct, input bit cn, input bit rd);
    @(posedge clk);
    #1;
    reset      = r;
    coin_valid = cv;
    coin_type  = 2'(ct);
    cancel     = cn;
    chg_ready  = rd;
    for (int i = 0; i < 2; i++) begin
      emit(i);
      step(i);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
  endtask

  // Monitor: per cycle, status first, then reject, item and change events.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (evq[i].size() > 0) begin
        mon_e = evq[i].pop_front();
        chk("credit", i, int'(o_cr[i]), mon_e.a);
        chk("busy", i, int'(o_busy[i]), mon_e.b);
        chk("sales_count", i, int'(o_sc[i]), mon_e.c);
        chk("chg_valid", i, int'(o_cv[i]), mon_e.d);
        for (int k = K_REJ; k <= K_CHG; k++) begin
          bit obs;
          bit exp;
          obs = (k == K_REJ) ? o_rej[i] : (k == K_ITEM) ? o_item[i] : (o_cv[i] && chg_ready);
          exp = (evq[i].size() > 0) && (evq[i][0].kind == k);
          chk((k == K_REJ) ? "coin_reject" : (k == K_ITEM) ? "item_out" : "chg_handshake",
              i, int'(obs), int'(exp));
          if (exp) begin
            mon_e = evq[i].pop_front();
            if (obs && k == K_CHG) chk("chg_type", i, int'(o_ct[i]), mon_e.a);
          end
        end
      end
    end
  end

  initial begin
    m_price[0] = 5;
    m_price[1] = 15;
    for (int i = 0; i < 2; i++) begin
      m_credit[i] = 0;
      m_phase[i]  = PH_IDLE;
      m_sales[i]  = 0;
      m_rej[i]    = 1'b0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Farthing then penny: exact price, no change.
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 2, 1'b0, 1'b1);
    idle(3);

    // Two pennies: vend then halfpenny + farthing change back to back.
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 2, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 2, 1'b0, 1'b1);
    idle(5);

    // Credit 7, dispenser stalls for three cycles in CHANGE.
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 2, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle(4);

    // Credit 3 then cancel; later cancel together with a penny.
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b1);
    idle(4);
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 2, 1'b1, 1'b1);
    idle(4);

    // Overflow on the PRICE=15 instance, then exact fill; invalid coin type.
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
    repeat (4) cyc(1'b0, 1'b1, 2, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 3, 1'b0, 1'b1);
    idle(4);
    cyc(1'b0, 1'b1, 3, 1'b0, 1'b1);
    idle(2);

    // Penny during CHANGE, then reset while change is still owed.
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 2, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
    idle(3);

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 2) == 0),
          int'($urandom_range(0, 3)),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 3) != 0));
    end
    idle(20);

    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) chk("queue_drain", i, evq[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_credit_ctrl.md
Name: vend_credit_ctrl

Overview:
- Sequential successor to the combinational vend/change output logic.
- Accumulates inserted coins into a parametrised-width credit register.
- Dispenses an item when credit reaches a parametrised price.
- Pays change, or a full refund on cancel, one coin at a time to the coin dispenser over a valid/ready handshake. Sits between the coin acceptor and the item/coin dispensers.

Parameters:
- W, 4: credit register width in farthings; max credit 2^W-1.
- PRICE, 5: item price in farthings. Must satisfy 1 <= PRICE <= 2^W-1.
- CNT_W, 8: width of the sales counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- coin_valid  in  1  coin presented this cycle.
- coin_type  in  2  coin type: 00 farthing = 1, 01 halfpenny = 2, 10 penny = 4, 11 invalid.
- cancel  in  1  request refund of current credit.
- coin_reject  out  1  one-cycle pulse: presented coin not accepted.
- item_out  out  1  one-cycle dispense pulse.
- chg_valid  out  1  change coin request to dispenser.
- chg_type  out  2  change coin type, same encoding as coin_type (never 11).
- chg_ready  in  1  dispenser accepts the current change coin.
- credit  out  W  current credit register.
- busy  out  1  high in VEND, CHANGE or REFUND.
- sales_count  out  CNT_W  items vended; wraps modulo 2^CNT_W.

Behaviour:
- Reset (sync, active-high): state = COLLECT, credit = 0, sales_count = 0. All pulse/valid outputs = 0. Reset mid-payout abandons the remaining credit, with no further chg_valid.
- States: COLLECT, VEND, CHANGE, REFUND. item_out, chg_valid and busy decode from the registered state. chg_type decodes from the registered credit.
- COLLECT, accepted coin (coin_valid=1, coin_type != 11, credit+val <= 2^W-1, cancel=0):
  - At the edge, credit <= credit+val.
  - If credit+val >= PRICE, go to VEND; otherwise stay in COLLECT.
- COLLECT, rejected coin (invalid type, overflow, or cancel=1 in the same cycle): coin_reject = 1 on the next cycle; credit unchanged.
- COLLECT, cancel=1 with credit > 0: go to REFUND. Cancel with credit = 0 is ignored. Cancel wins over a coin in the same cycle.
- VEND (exactly one cycle):
  - item_out = 1.
  - At exit: credit <= credit-PRICE and sales_count += 1.
  - Next state is CHANGE if the remainder > 0, else COLLECT.
- CHANGE / REFUND:
  - chg_valid = 1.
  - chg_type is greedy on credit: penny if credit >= 4, else halfpenny if >= 2, else farthing.
  - chg_valid and chg_type stay stable until a chg_valid & chg_ready edge.
  - At that edge credit -= coin value. When credit reaches 0, go to COLLECT at the same edge; chg_valid drops the next cycle.
  - REFUND never asserts item_out and never increments sales_count.
- Coins presented in VEND, CHANGE or REFUND are rejected (coin_reject pulse). cancel is ignored outside COLLECT.
- Latency:
  - Price-reaching coin edge to item_out: 1 cycle.
  - VEND to first chg_valid: 1 cycle.
  - Back-to-back change handshakes are allowed, one coin per cycle.
- Arithmetic: all sums are computed at W+1 bits for the overflow check. The credit register never wraps.

Test Plan:
- W=4, PRICE=5: farthing then penny. Response: credit 1 then 5; item_out pulses one cycle; no chg_valid; credit 0; sales_count 1.
- Penny, penny (credit 8), chg_ready=1. Response: item_out; chg_type 01 then 00 on consecutive cycles; credit 3 -> 1 -> 0; back in COLLECT.
- Credit 7 with chg_ready held low for 3 cycles. Response: chg_valid=1 and chg_type=01 stable for all 3 cycles, credit stays 2, no extra coins paid.
- Credit 3, cancel. Response: REFUND pays halfpenny then farthing; item_out never pulses; sales_count unchanged. Cancel together with a penny: coin_reject pulses, credit unchanged.
- PRICE=15 instance: three pennies (credit 12), then a fourth penny. Response: coin_reject pulses, credit stays 12. Then a halfpenny (14), then a farthing (15): item_out pulses, credit 0. coin_type 11 is always rejected.
- Penny inserted during CHANGE: coin_reject pulses, credit unaffected. Assert reset mid-CHANGE: next cycle chg_valid=0, credit=0, state COLLECT, sales_count=0.
